// File: rtl/mips_pkg.sv
// mips_pkg: opcode, funct, ALU-control and controller-state definitions shared by the tinymips cores.
package mips_pkg;

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_BEQ   = 6'b000100,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcode_e;

   localparam logic [5:0] F_ADD = 6'd32;
   localparam logic [5:0] F_SUB = 6'd34;
   localparam logic [5:0] F_AND = 6'd36;
   localparam logic [5:0] F_OR  = 6'd37;
   localparam logic [5:0] F_SLT = 6'd42;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } alu_op_e;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
      S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
   } ctrl_state_e;

   localparam logic [1:0] PC_ALU      = 2'd0;
   localparam logic [1:0] PC_ALUOUT   = 2'd1;
   localparam logic [1:0] PC_JUMP     = 2'd2;
   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH = 2'd3;

endpackage

// File: rtl/mips_alu_dec.sv
// mips_alu_dec: maps alu_op (+ funct for R-type) to the ALU function code and flags unknown funct.
//   funct     in  instr[5:0]
//   alu_op    in  ADD / SUB / FUNCT request from the main controller
//   alu_ctrl  out ALU function code
//   bad_funct out funct not decodable (only meaningful when alu_op = FUNCT)
module mips_alu_dec
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   input  alu_op_e    alu_op,
   output alu_ctrl_e  alu_ctrl,
   output logic       bad_funct
);

   always_comb begin
      alu_ctrl  = ALU_ADD;
      bad_funct = 1'b0;
      case (alu_op)
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_FUNCT:
            case (funct)
               F_ADD:   alu_ctrl = ALU_ADD;
               F_SUB:   alu_ctrl = ALU_SUB;
               F_AND:   alu_ctrl = ALU_AND;
               F_OR:    alu_ctrl = ALU_OR;
               F_SLT:   alu_ctrl = ALU_SLT;
               default: bad_funct = 1'b1;
            endcase
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle tinymips main controller (Moore FSM with req/ready memory handshake).
//   CLK, RST           clock, asynchronous active-high reset
//   op, funct, zero    instruction fields and ALU zero flag from the datapath
//   mem_ready          memory completes the pending access this cycle
//   mem_req, mem_we    memory request and write qualifier; iord picks PC (0) or ALUOut (1)
//   ir_write, pc_en    instruction register / PC load strobes; pc_src picks ALU, ALUOut, jump target
//   alu_src_a/b        ALU operand selects; alu_ctrl ALU function code
//   reg_dst, mem_to_reg, reg_write   register-file write controls
//   instr_done         one-cycle retire pulse; illegal one-cycle undecodable op/funct pulse
module mips_mc_ctrl
   import mips_pkg::*;
#(
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       instr_done,
   output logic       illegal
);

   ctrl_state_e state, state_nx;
   alu_op_e     alu_op;
   alu_ctrl_e   alu_ctrl_w;
   logic        bad_funct;
   logic        mem_req_s, mem_we_s, ir_write_s, pc_en_s, reg_write_s, instr_done_s, illegal_s;

   mips_alu_dec u_alu_dec (
      .funct     (funct),
      .alu_op    (alu_op),
      .alu_ctrl  (alu_ctrl_w),
      .bad_funct (bad_funct)
   );

   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= S_FETCH;
      else     state <= state_nx;

   always_comb begin
      state_nx     = state;
      mem_req_s    = 1'b0;
      mem_we_s     = 1'b0;
      iord         = 1'b0;
      ir_write_s   = 1'b0;
      pc_en_s      = 1'b0;
      pc_src       = PC_ALU;
      alu_src_a    = 1'b0;
      alu_src_b    = SRCB_B;
      alu_op       = ALUOP_ADD;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write_s  = 1'b0;
      instr_done_s = 1'b0;
      illegal_s    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req_s  = 1'b1;
            alu_src_b  = SRCB_FOUR;
            ir_write_s = mem_ready;
            pc_en_s    = mem_ready;
            state_nx   = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH;
            case (op)
               OP_LW, OP_SW: state_nx = S_MEMADR;
               OP_RTYPE:     state_nx = S_EXECUTE;
               OP_BEQ:       state_nx = S_BRANCH;
               OP_ADDI:      state_nx = S_ADDIEX;
               OP_J:         state_nx = S_JUMP;
               default: begin
                  illegal_s = 1'b1;
                  state_nx  = ILLEGAL_TRAP ? S_HALT : S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_nx  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req_s = 1'b1;
            iord      = 1'b1;
            state_nx  = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write_s  = 1'b1;
            mem_to_reg   = 1'b1;
            instr_done_s = 1'b1;
            state_nx     = S_FETCH;
         end
         S_MEMWR: begin
            mem_req_s    = 1'b1;
            mem_we_s     = 1'b1;
            iord         = 1'b1;
            instr_done_s = mem_ready;
            state_nx     = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
            illegal_s = bad_funct;
            state_nx  = S_ALUWB;
         end
         S_ALUWB: begin
            // funct is still held in the IR, so the bad-funct flag is recomputed here to block the write
            alu_op       = ALUOP_FUNCT;
            reg_write_s  = ~bad_funct;
            reg_dst      = 1'b1;
            instr_done_s = 1'b1;
            state_nx     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a    = 1'b1;
            alu_op       = ALUOP_SUB;
            pc_src       = PC_ALUOUT;
            pc_en_s      = zero;
            instr_done_s = 1'b1;
            state_nx     = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_nx  = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write_s  = 1'b1;
            instr_done_s = 1'b1;
            state_nx     = S_FETCH;
         end
         S_JUMP: begin
            pc_src       = PC_JUMP;
            pc_en_s      = 1'b1;
            instr_done_s = 1'b1;
            state_nx     = S_FETCH;
         end
         S_HALT:  state_nx = S_HALT;
         default: state_nx = S_FETCH;
      endcase
   end

   // Strobes are masked by RST directly so a reset mid-access drops them without waiting for a clock.
   assign mem_req    = mem_req_s & ~RST;
   assign mem_we     = mem_we_s & ~RST;
   assign ir_write   = ir_write_s & ~RST;
   assign pc_en      = pc_en_s & ~RST;
   assign reg_write  = reg_write_s & ~RST;
   assign instr_done = instr_done_s & ~RST;
   assign illegal    = illegal_s & ~RST;
   assign alu_ctrl   = alu_ctrl_w;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: self-checking bench for mips_mc_ctrl, trapping and non-trapping instances in lockstep.
module tb_mips_mc_ctrl;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
   localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4, P_MEMWR = 5;
   localparam int P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ADDIEX = 9, P_ADDIWB = 10, P_JUMP = 11;
   localparam int P_HALT = 12, P_RST = 13;

   typedef struct packed {
      logic       mem_req, mem_we, iord, ir_write, pc_en;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_ctrl;
      logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal;
   } sig_t;

   logic       CLK = 1'b0, RST = 1'b0;
   logic [5:0] op = '0, funct = '0;
   logic       zero = 1'b0, mem_ready = 1'b0;
   wire [17:0] ot, os;
   int         n_cmp = 0, n_bad = 0;
   bit         halted_t = 1'b0;

   always #5 CLK = ~CLK;

   mips_mc_ctrl #(.ILLEGAL_TRAP(1'b1)) dut_t (
      .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(ot[17]), .mem_we(ot[16]), .iord(ot[15]), .ir_write(ot[14]), .pc_en(ot[13]),
      .pc_src(ot[12:11]), .alu_src_a(ot[10]), .alu_src_b(ot[9:8]), .alu_ctrl(ot[7:5]),
      .reg_dst(ot[4]), .mem_to_reg(ot[3]), .reg_write(ot[2]), .instr_done(ot[1]), .illegal(ot[0]));

   mips_mc_ctrl #(.ILLEGAL_TRAP(1'b0)) dut_s (
      .CLK(CLK), .RST(RST), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(os[17]), .mem_we(os[16]), .iord(os[15]), .ir_write(os[14]), .pc_en(os[13]),
      .pc_src(os[12:11]), .alu_src_a(os[10]), .alu_src_b(os[9:8]), .alu_ctrl(os[7:5]),
      .reg_dst(os[4]), .mem_to_reg(os[3]), .reg_write(os[2]), .instr_done(os[1]), .illegal(os[0]));

   function automatic logic [2:0] ref_alu(input logic [5:0] fn, output bit ok);
      ok = 1'b1;
      case (fn)
         6'd32:   return 3'b010;
         6'd34:   return 3'b110;
         6'd36:   return 3'b000;
         6'd37:   return 3'b001;
         6'd42:   return 3'b111;
         default: begin ok = 1'b0; return 3'b010; end
      endcase
   endfunction

   // Expected value and care-mask for one cycle of a given instruction phase; strobes are always checked.
   function automatic void model(input int ph, input logic rdy, zb, input logic [5:0] o, fn,
                                 output sig_t e, output sig_t m);
      bit ok;
      logic [2:0] ac;
      ac = ref_alu(fn, ok);
      e = '0;
      m = '0;
      {m.mem_req, m.mem_we, m.ir_write, m.pc_en, m.reg_write, m.instr_done, m.illegal} = '1;
      case (ph)
         P_FETCH, P_RST: begin
            e.mem_req = (ph == P_FETCH);
            e.ir_write = (ph == P_FETCH) && rdy;
            e.pc_en = (ph == P_FETCH) && rdy;
            e.alu_src_b = 2'd1;
            e.alu_ctrl = 3'b010;
            {m.iord, m.alu_src_a} = '1;
            m.pc_src = '1;
            m.alu_src_b = '1;
            m.alu_ctrl = '1;
         end
         P_DECODE: begin
            e.alu_src_b = 2'd3;
            e.alu_ctrl = 3'b010;
            e.illegal = !(o inside {LW, SW, RT, BEQ, ADDI, JMP});
            m.alu_src_a = 1'b1;
            m.alu_src_b = '1;
            m.alu_ctrl = '1;
         end
         P_MEMADR, P_ADDIEX: begin
            e.alu_src_a = 1'b1;
            e.alu_src_b = 2'd2;
            e.alu_ctrl = 3'b010;
            m.alu_src_a = 1'b1;
            m.alu_src_b = '1;
            m.alu_ctrl = '1;
         end
         P_MEMRD: begin
            e.mem_req = 1'b1;
            e.iord = 1'b1;
            m.iord = 1'b1;
         end
         P_MEMWB, P_ADDIWB: begin
            e.reg_write = 1'b1;
            e.mem_to_reg = (ph == P_MEMWB);
            e.instr_done = 1'b1;
            {m.reg_dst, m.mem_to_reg} = '1;
         end
         P_MEMWR: begin
            {e.mem_req, e.mem_we, e.iord} = '1;
            e.instr_done = rdy;
            m.iord = 1'b1;
         end
         P_EXEC: begin
            e.alu_src_a = 1'b1;
            e.alu_ctrl = ac;
            e.illegal = !ok;
            m.alu_src_a = 1'b1;
            m.alu_src_b = '1;
            m.alu_ctrl = {3{ok}};
         end
         P_ALUWB: begin
            e.reg_write = ok;
            e.reg_dst = 1'b1;
            e.instr_done = 1'b1;
            {m.reg_dst, m.mem_to_reg} = '1;
         end
         P_BRANCH: begin
            e.alu_src_a = 1'b1;
            e.alu_ctrl = 3'b110;
            e.pc_src = 2'd1;
            e.pc_en = zb;
            e.instr_done = 1'b1;
            m.alu_src_a = 1'b1;
            m.alu_src_b = '1;
            m.alu_ctrl = '1;
            m.pc_src = '1;
         end
         P_JUMP: begin
            e.pc_src = 2'd2;
            e.pc_en = 1'b1;
            e.instr_done = 1'b1;
            m.pc_src = '1;
         end
         default: e = '0;
      endcase
   endfunction

   task automatic chk(input int ph_t, input int ph_s);
      sig_t et, mt, es, ms;
      model(ph_t, mem_ready, zero, op, funct, et, mt);
      model(ph_s, mem_ready, zero, op, funct, es, ms);
      n_cmp++;
      assert ((ot & mt) === (et & mt)) else begin
         n_bad++;
         $error("FAIL trap_ph%0d t=%0t: observed %h expected %h (mask %h)", ph_t, $time, ot, et, mt);
      end
      n_cmp++;
      assert ((os & ms) === (es & ms)) else begin
         n_bad++;
         $error("FAIL skip_ph%0d t=%0t: observed %h expected %h (mask %h)", ph_s, $time, os, es, ms);
      end
   endtask

   task automatic cyc(input int ph, input logic rdy, input logic [5:0] o, fn, input logic z);
      @(negedge CLK);
      mem_ready = rdy;
      op = o;
      funct = fn;
      zero = z;
      #1 chk(halted_t ? P_HALT : ph, ph);
   endtask

   task automatic do_instr(input logic [5:0] o, fn, input logic z, input int fw, mw);
      for (int i = 0; i <= fw; i++) cyc(P_FETCH, i == fw, 6'($urandom), 6'($urandom), z);
      cyc(P_DECODE, 1'($urandom), o, fn, z);
      case (o)
         LW: begin
            cyc(P_MEMADR, 1'($urandom), o, fn, z);
            for (int i = 0; i <= mw; i++) cyc(P_MEMRD, i == mw, o, fn, z);
            cyc(P_MEMWB, 1'($urandom), o, fn, z);
         end
         SW: begin
            cyc(P_MEMADR, 1'($urandom), o, fn, z);
            for (int i = 0; i <= mw; i++) cyc(P_MEMWR, i == mw, o, fn, z);
         end
         RT: begin
            cyc(P_EXEC, 1'($urandom), o, fn, z);
            cyc(P_ALUWB, 1'($urandom), o, fn, z);
         end
         BEQ:  cyc(P_BRANCH, 1'($urandom), o, fn, z);
         ADDI: begin
            cyc(P_ADDIEX, 1'($urandom), o, fn, z);
            cyc(P_ADDIWB, 1'($urandom), o, fn, z);
         end
         JMP:  cyc(P_JUMP, 1'($urandom), o, fn, z);
         default: halted_t = 1'b1;
      endcase
   endtask

   task automatic rand_instr();
      logic [5:0] ops [6] = '{LW, SW, RT, BEQ, ADDI, JMP};
      logic [5:0] fns [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
      logic [5:0] fn;
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      do_instr(ops[$urandom_range(0, 5)], fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
   endtask

   task automatic do_reset();
      @(negedge CLK);
      mem_ready = 1'b1;
      RST = 1'b1;
      #1 chk(P_RST, P_RST);
      @(negedge CLK);
      #1 chk(P_RST, P_RST);
      mem_ready = 1'b0;
      RST = 1'b0;
      halted_t = 1'b0;
      #1 chk(P_FETCH, P_FETCH);
   endtask

   initial begin
      mem_ready = 1'b1;
      #1 RST = 1'b1;
      #1 chk(P_RST, P_RST);
      @(negedge CLK);
      #1 chk(P_RST, P_RST);
      mem_ready = 1'b0;
      RST = 1'b0;
      #1 chk(P_FETCH, P_FETCH);

      do_instr(LW, 6'd0, 1'b0, 0, 0);
      do_instr(SW, 6'd0, 1'b0, 2, 3);
      do_instr(RT, 6'd32, 1'b0, 0, 0);
      do_instr(RT, 6'd34, 1'b0, 1, 0);
      do_instr(RT, 6'd36, 1'b1, 0, 0);
      do_instr(RT, 6'd37, 1'b0, 0, 0);
      do_instr(RT, 6'd42, 1'b0, 0, 0);
      do_instr(RT, 6'd0, 1'b0, 0, 0);
      do_instr(BEQ, 6'd0, 1'b1, 0, 0);
      do_instr(BEQ, 6'd0, 1'b0, 0, 0);
      do_instr(JMP, 6'd0, 1'b0, 0, 0);
      do_instr(ADDI, 6'd5, 1'b1, 0, 0);
      for (int k = 0; k < 40; k++) rand_instr();

      do_instr(6'b111111, 6'd0, 1'b0, 1, 0);
      for (int k = 0; k < 8; k++) rand_instr();
      do_reset();
      for (int k = 0; k < 10; k++) rand_instr();

      cyc(P_FETCH, 1'b1, LW, 6'd0, 1'b0);
      cyc(P_DECODE, 1'b0, LW, 6'd0, 1'b0);
      cyc(P_MEMADR, 1'b0, LW, 6'd0, 1'b0);
      cyc(P_MEMRD, 1'b0, LW, 6'd0, 1'b0);
      cyc(P_MEMRD, 1'b0, LW, 6'd0, 1'b0);
      #2 RST = 1'b1;
      #1 chk(P_RST, P_RST);
      @(negedge CLK);
      #1 chk(P_RST, P_RST);
      RST = 1'b0;
      #1 chk(P_FETCH, P_FETCH);
      for (int k = 0; k < 20; k++) rand_instr();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
